// File: rtl/demux1to2_32_if.sv
// Stream bundle for the 1-to-2 demultiplexer: one valid/ready input stream and
// two valid/ready output streams.
//   master : the environment (drives input beats, consumes both outputs)
//   slave  : the demultiplexer itself
interface demux1to2_32_if #(
  parameter int unsigned WIDTH = 32
);
  logic [WIDTH-1:0] Input_Data;
  logic             Input_Sel;
  logic             Input_Last;
  logic             Input_Valid;
  logic             Input_Ready;

  logic [WIDTH-1:0] Output0_Data;
  logic             Output0_Last;
  logic             Output0_Valid;
  logic             Output0_Ready;

  logic [WIDTH-1:0] Output1_Data;
  logic             Output1_Last;
  logic             Output1_Valid;
  logic             Output1_Ready;

  modport master (
    output Input_Data, Input_Sel, Input_Last, Input_Valid,
    input  Input_Ready,
    input  Output0_Data, Output0_Last, Output0_Valid,
    output Output0_Ready,
    input  Output1_Data, Output1_Last, Output1_Valid,
    output Output1_Ready
  );

  modport slave (
    input  Input_Data, Input_Sel, Input_Last, Input_Valid,
    output Input_Ready,
    output Output0_Data, Output0_Last, Output0_Valid,
    input  Output0_Ready,
    output Output1_Data, Output1_Last, Output1_Valid,
    input  Output1_Ready
  );
endinterface

// File: rtl/demux1to2_32.sv
// Registered 1-to-2 stream demultiplexer. The destination is taken from
// Input_Sel on the first beat of a packet and locked until its Last beat.
// Each output has a one-entry register slot that drains independently.
// Ports:
//   Clk, Rst_n     : clock, asynchronous active-low reset
//   bus (slave)    : input stream and both output streams
//   Busy           : a packet is in progress (destination locked)
//   Count0/Count1  : wrapping counts of beats delivered on each output
module demux1to2_32 #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Rst_n,
  demux1to2_32_if.slave    bus,
  output logic             Busy,
  output logic [CNT_W-1:0] Count0,
  output logic [CNT_W-1:0] Count1
);

  typedef enum logic [1:0] {StIdle, StLock0, StLock1} state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] o0_data_q, o0_data_d, o1_data_q, o1_data_d;
  logic             o0_last_q, o0_last_d, o1_last_q, o1_last_d;
  logic             o0_valid_q, o0_valid_d, o1_valid_q, o1_valid_d;
  logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

  logic target;
  logic in_ready;
  logic accept;
  logic deliver0, deliver1;

  // Destination of the beat currently offered on the input.
  always_comb begin
    target = bus.Input_Sel;
    unique case (state_q)
      StLock0: target = 1'b0;
      StLock1: target = 1'b1;
      default: target = bus.Input_Sel;
    endcase
  end

  // Ready looks only at the target slot, so a stalled non-target output never
  // blocks the input, and Input_Valid never feeds back into Input_Ready.
  always_comb begin
    in_ready = target ? (!o1_valid_q || bus.Output1_Ready)
                      : (!o0_valid_q || bus.Output0_Ready);
    accept   = bus.Input_Valid && in_ready;
    deliver0 = o0_valid_q && bus.Output0_Ready;
    deliver1 = o1_valid_q && bus.Output1_Ready;
  end

  always_comb begin
    state_d = state_q;
    if (accept) begin
      if (bus.Input_Last) begin
        state_d = StIdle;
      end else if (state_q == StIdle) begin
        state_d = bus.Input_Sel ? StLock1 : StLock0;
      end
    end
  end

  // Slots: a load in the same cycle as a delivery overrides the clear.
  always_comb begin
    o0_data_d  = o0_data_q;
    o0_last_d  = o0_last_q;
    o0_valid_d = o0_valid_q;
    o1_data_d  = o1_data_q;
    o1_last_d  = o1_last_q;
    o1_valid_d = o1_valid_q;
    cnt0_d     = cnt0_q;
    cnt1_d     = cnt1_q;

    if (deliver0) begin
      o0_valid_d = 1'b0;
      cnt0_d     = cnt0_q + CNT_W'(1);
    end
    if (deliver1) begin
      o1_valid_d = 1'b0;
      cnt1_d     = cnt1_q + CNT_W'(1);
    end

    if (accept && !target) begin
      o0_data_d  = bus.Input_Data;
      o0_last_d  = bus.Input_Last;
      o0_valid_d = 1'b1;
    end
    if (accept && target) begin
      o1_data_d  = bus.Input_Data;
      o1_last_d  = bus.Input_Last;
      o1_valid_d = 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q    <= StIdle;
      o0_data_q  <= '0;
      o0_last_q  <= 1'b0;
      o0_valid_q <= 1'b0;
      o1_data_q  <= '0;
      o1_last_q  <= 1'b0;
      o1_valid_q <= 1'b0;
      cnt0_q     <= '0;
      cnt1_q     <= '0;
    end else begin
      state_q    <= state_d;
      o0_data_q  <= o0_data_d;
      o0_last_q  <= o0_last_d;
      o0_valid_q <= o0_valid_d;
      o1_data_q  <= o1_data_d;
      o1_last_q  <= o1_last_d;
      o1_valid_q <= o1_valid_d;
      cnt0_q     <= cnt0_d;
      cnt1_q     <= cnt1_d;
    end
  end

  assign bus.Input_Ready   = in_ready;
  assign bus.Output0_Data  = o0_data_q;
  assign bus.Output0_Last  = o0_last_q;
  assign bus.Output0_Valid = o0_valid_q;
  assign bus.Output1_Data  = o1_data_q;
  assign bus.Output1_Last  = o1_last_q;
  assign bus.Output1_Valid = o1_valid_q;
  assign Busy              = (state_q != StIdle);
  assign Count0            = cnt0_q;
  assign Count1            = cnt1_q;

endmodule

// File: tb/tb_demux1to2_32.sv
// Scoreboard bench for demux1to2_32: stimulus pushes expected beats per output,
// a negedge monitor pops and compares on every delivery.
module tb_demux1to2_32;

  logic        Clk;
  logic        Rst_n;
  logic        Busy;
  logic [15:0] Count0;
  logic [15:0] Count1;

  demux1to2_32_if #(.WIDTH(32)) bus ();

  demux1to2_32 #(
    .WIDTH (32),
    .CNT_W (16)
  ) dut (
    .Clk    (Clk),
    .Rst_n  (Rst_n),
    .bus    (bus.slave),
    .Busy   (Busy),
    .Count0 (Count0),
    .Count1 (Count1)
  );

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } beat_t;

  beat_t q0[$];
  beat_t q1[$];
  beat_t e0, e1;

  int checks   = 0;
  int failures = 0;
  logic busy_seen = 1'b0;
  int w;

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [31:0] d, input logic s, input logic l, output int waits);
    bus.Input_Data  = d;
    bus.Input_Sel   = s;
    bus.Input_Last  = l;
    bus.Input_Valid = 1'b1;
    waits = 0;
    @(negedge Clk);
    while (!bus.Input_Ready && waits < 50) begin
      waits++;
      @(negedge Clk);
    end
    if (!bus.Input_Ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: got ready=0 expected ready=1 for data 0x%08h", d);
    end
    @(posedge Clk);
    #1;
    bus.Input_Valid = 1'b0;
  endtask

  task automatic push0(input logic [31:0] d, input logic l);
    q0.push_back('{data: d, last: l});
  endtask

  task automatic push1(input logic [31:0] d, input logic l);
    q1.push_back('{data: d, last: l});
  endtask

  // Monitor
  always @(negedge Clk) begin
    if (Rst_n) begin
      busy_seen = busy_seen | Busy;
      if (bus.Output0_Valid && bus.Output0_Ready) begin
        if (q0.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL out0_unexpected: got 0x%08h expected no beat", bus.Output0_Data);
        end else begin
          e0 = q0.pop_front();
          chk("out0_data", bus.Output0_Data, e0.data);
          chk("out0_last", {31'd0, bus.Output0_Last}, {31'd0, e0.last});
        end
      end
      if (bus.Output1_Valid && bus.Output1_Ready) begin
        if (q1.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL out1_unexpected: got 0x%08h expected no beat", bus.Output1_Data);
        end else begin
          e1 = q1.pop_front();
          chk("out1_data", bus.Output1_Data, e1.data);
          chk("out1_last", {31'd0, bus.Output1_Last}, {31'd0, e1.last});
        end
      end
    end
  end

  initial begin
    Rst_n             = 1'b1;
    bus.Input_Data    = '0;
    bus.Input_Sel     = 1'b0;
    bus.Input_Last    = 1'b0;
    bus.Input_Valid   = 1'b0;
    bus.Output0_Ready = 1'b0;
    bus.Output1_Ready = 1'b0;
    #1 Rst_n = 1'b0;
    #2;
    chk("rst0_valid0", {31'd0, bus.Output0_Valid}, 32'd0);
    chk("rst0_valid1", {31'd0, bus.Output1_Valid}, 32'd0);
    chk("rst0_busy",   {31'd0, Busy}, 32'd0);
    chk("rst0_ready",  {31'd0, bus.Input_Ready}, 32'd1);
    chk("rst0_count0", {16'd0, Count0}, 32'd0);
    chk("rst0_count1", {16'd0, Count1}, 32'd0);
    @(negedge Clk);
    Rst_n = 1'b1;
    @(posedge Clk);
    #1;

    // Single-beat routing
    bus.Output0_Ready = 1'b1;
    bus.Output1_Ready = 1'b1;
    busy_seen = 1'b0;
    push0(32'hA000_0001, 1'b1);
    send(32'hA000_0001, 1'b0, 1'b1, w);
    push1(32'hB000_0002, 1'b1);
    send(32'hB000_0002, 1'b1, 1'b1, w);
    repeat (2) @(posedge Clk);
    #1;
    chk("single_count0", {16'd0, Count0}, 32'd1);
    chk("single_count1", {16'd0, Count1}, 32'd1);
    chk("single_busy_never", {31'd0, busy_seen}, 32'd0);

    // Packet lock: Sel changes after beat 1 must be ignored
    for (int i = 0; i < 4; i++) begin
      push0(32'h10 + i, i == 3);
      send(32'h10 + i, i != 0, i == 3, w);
      chk("pkt_busy", {31'd0, Busy}, {31'd0, (i != 3)});
    end
    repeat (2) @(posedge Clk);
    #1;

    // Backpressure on output 0
    bus.Output0_Ready = 1'b0;
    push0(32'h55, 1'b1);
    send(32'h55, 1'b0, 1'b1, w);
    push0(32'h66, 1'b1);
    bus.Input_Data  = 32'h66;
    bus.Input_Sel   = 1'b0;
    bus.Input_Last  = 1'b1;
    bus.Input_Valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge Clk);
      chk("bp_ready_low",   {31'd0, bus.Input_Ready}, 32'd0);
      chk("bp_hold_data",   bus.Output0_Data, 32'h55);
      chk("bp_hold_valid",  {31'd0, bus.Output0_Valid}, 32'd1);
    end
    @(posedge Clk);
    #1;
    bus.Output0_Ready = 1'b1;
    @(negedge Clk);
    chk("bp_ready_up", {31'd0, bus.Input_Ready}, 32'd1);
    @(posedge Clk);
    #1;
    bus.Input_Valid = 1'b0;
    chk("bp_next_data",  bus.Output0_Data, 32'h66);
    chk("bp_next_valid", {31'd0, bus.Output0_Valid}, 32'd1);
    repeat (2) @(posedge Clk);
    #1;

    // Independence: stalled output 0 does not block output 1
    bus.Output0_Ready = 1'b0;
    push0(32'h88, 1'b1);
    send(32'h88, 1'b0, 1'b1, w);
    push1(32'h77, 1'b1);
    send(32'h77, 1'b1, 1'b1, w);
    chk("indep_wait", w, 32'd0);
    chk("indep_o0_data",  bus.Output0_Data, 32'h88);
    chk("indep_o0_valid", {31'd0, bus.Output0_Valid}, 32'd1);
    repeat (2) @(posedge Clk);
    #1;
    chk("indep_o0_hold", bus.Output0_Data, 32'h88);
    bus.Output0_Ready = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    chk("total_count0", {16'd0, Count0}, 32'd8);
    chk("total_count1", {16'd0, Count1}, 32'd2);

    // Reset with both slots full
    bus.Output0_Ready = 1'b0;
    bus.Output1_Ready = 1'b0;
    send(32'hC0, 1'b0, 1'b1, w);
    send(32'hC1, 1'b1, 1'b1, w);
    #1 Rst_n = 1'b0;
    #1;
    chk("rst_valid0", {31'd0, bus.Output0_Valid}, 32'd0);
    chk("rst_valid1", {31'd0, bus.Output1_Valid}, 32'd0);
    chk("rst_data0",  bus.Output0_Data, 32'd0);
    chk("rst_data1",  bus.Output1_Data, 32'd0);
    chk("rst_last0",  {31'd0, bus.Output0_Last}, 32'd0);
    chk("rst_last1",  {31'd0, bus.Output1_Last}, 32'd0);
    chk("rst_count0", {16'd0, Count0}, 32'd0);
    chk("rst_count1", {16'd0, Count1}, 32'd0);
    chk("rst_busy",   {31'd0, Busy}, 32'd0);
    chk("rst_ready",  {31'd0, bus.Input_Ready}, 32'd1);
    @(negedge Clk);
    Rst_n = 1'b1;
    @(posedge Clk);
    #1;

    // Counter wrap on output 1
    bus.Output1_Ready = 1'b1;
    for (int i = 0; i < 65537; i++) begin
      push1(i, 1'b1);
      send(i, 1'b1, 1'b1, w);
    end
    repeat (2) @(posedge Clk);
    #1;
    chk("wrap_count1", {16'd0, Count1}, 32'd1);
    chk("wrap_count0", {16'd0, Count0}, 32'd0);

    // Mid-packet reset clears the lock
    bus.Output0_Ready = 1'b1;
    push0(32'hD0, 1'b0);
    send(32'hD0, 1'b0, 1'b0, w);
    push0(32'hD1, 1'b0);
    send(32'hD1, 1'b0, 1'b0, w);
    chk("mid_busy", {31'd0, Busy}, 32'd1);
    @(posedge Clk);
    #1 Rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", {31'd0, Busy}, 32'd0);
    @(negedge Clk);
    Rst_n = 1'b1;
    @(posedge Clk);
    #1;
    bus.Output1_Ready = 1'b0;
    push1(32'hE0, 1'b1);
    send(32'hE0, 1'b1, 1'b1, w);
    chk("post_rst_o1_valid", {31'd0, bus.Output1_Valid}, 32'd1);
    chk("post_rst_o1_data",  bus.Output1_Data, 32'hE0);
    chk("post_rst_o0_valid", {31'd0, bus.Output0_Valid}, 32'd0);
    bus.Output1_Ready = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    chk("post_rst_count1", {16'd0, Count1}, 32'd1);
    chk("drain_q0", q0.size(), 32'd0);
    chk("drain_q1", q1.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/demux1to2_32.md
# demux1to2_32

Registered 1-to-2 stream demultiplexer for 32-bit data: accepts one valid/ready input stream and steers each packet to Output0 or Output1. It is the splitting counterpart of the 2:1 32-bit select mux in the datapath, and it is used where one producer feeds two consumers. The routing decision is made on the first beat of a packet and held until the Last beat. Each output has its own one-entry register slot. Per-output beat counters support debug and verification.

## Interface
- WIDTH, 32, data width of input and both outputs
- CNT_W, 16, width of per-output delivered-beat counters

- Clk  in  1  rising-edge clock
- Rst_n  in  1  reset, asynchronous, active-low
- Input_Data  in  WIDTH  input beat data
- Input_Sel  in  1  destination select, 0 = Output0, 1 = Output1; sampled only on a packet's first beat
- Input_Last  in  1  marks final beat of packet
- Input_Valid  in  1  input beat present
- Input_Ready  out  1  block accepts input beat this cycle
- Output0_Data / Output1_Data  out  WIDTH  registered output data
- Output0_Last / Output1_Last  out  1  registered Last flag
- Output0_Valid / Output1_Valid  out  1  output slot holds a beat
- Output0_Ready / Output1_Ready  in  1  downstream accepts beat
- Busy  out  1  packet in progress (select locked)
- Count0 / Count1  out  CNT_W  beats delivered on each output

## Operation
- A beat is accepted when Input_Valid & Input_Ready. A beat on output n is delivered when Outputn_Valid & Outputn_Ready.
- FSM states are IDLE, LOCK0, LOCK1.
  - In IDLE, the target is Input_Sel.
  - In LOCKn, the target is n, and Input_Sel is ignored.
- FSM transitions on an accepted beat:
  - IDLE with Last=0 goes to LOCK<Input_Sel>.
  - IDLE with Last=1 stays in IDLE.
  - LOCKn with Last=1 goes to IDLE.
  - LOCKn with Last=0 stays in LOCKn.
- Busy is 1 whenever state ≠ IDLE.
- Input_Ready = !Outputn_Valid | Outputn_Ready, where n is the current target. It depends only on the state, Input_Sel (in IDLE), slot status and Output_Ready. It has no combinational dependence on Input_Valid.
- An accepted beat loads the target slot with Data, Last and Valid=1.
  - If the slot delivers and loads in the same cycle, the new beat replaces the old one.
- A slot that delivers without loading clears Valid.
  - Data and Last hold their last values.
- The non-target slot drains independently and is never blocked by the target channel.
- Countn increments by 1 on each delivery and wraps from 2^CNT_W−1 to 0.
- Ordering is preserved per output. No ordering is defined between outputs.
- Reset values (Rst_n low, asynchronous):
  - state IDLE, Busy 0
  - both Valid 0, both Data 0, both Last 0
  - Count0 = Count1 = 0
  - Input_Ready therefore reads 1.
- Reset mid-packet discards both slots and the lock. No beat is delivered after reset deasserts unless it is newly accepted.

## Timing
- Latency: a beat accepted at edge k drives Outputn_Valid/Data/Last from just after edge k.
- Throughput: 1 beat/cycle per stream when the target Ready is held high.
- While Outputn_Valid & !Outputn_Ready, Outputn_Data/Last/Valid are stable.
- The state update and slot load occur on the same edge. The beat that causes LOCKn→IDLE still goes to slot n, and the next beat uses Input_Sel.
- Rst_n assertion takes effect immediately. Deassertion is used synchronously by the surrounding design; no internal synchronizer.

## Test plan
- Reset: pulse Rst_n low between edges with slots full → Output0/1_Valid=0, Data=0, Count0=Count1=0, Busy=0, Input_Ready=1 before the next edge.
- Single-beat routing: with both Ready=1, send 0xA0000001 (Sel=0, Last=1) then 0xB0000002 (Sel=1, Last=1).
  - Output0 shows 0xA0000001 for one cycle, then Output1 shows 0xB0000002.
  - Result: Count0=1, Count1=1, Busy never 1.
- Packet lock: send a 4-beat packet 0x10..0x13 with Sel=0 on beat 1 and Sel=1 on beats 2–4, Last on beat 4.
  - All four beats appear on Output0, with Output0_Last=1 only with 0x13.
  - Busy=1 from after beat 1 through beat 4's edge.
- Backpressure: Output0_Ready=0, send 0x55 and 0x66 to output 0.
  - 0x55 is held stable, and Input_Ready=0 with 0x66 pending.
  - Raise Ready: 0x66 is accepted that same cycle, 0x55 is delivered, and 0x66 is valid the next cycle.
- Independence: Output0 is full and stalled; send a single-beat 0x77 with Sel=1 → accepted immediately and delivered on Output1, while Output0 is unchanged.
- Wrap and mid-packet reset:
  - Deliver 65537 beats to Output1 → Count1=1.
  - Start a packet to Output0 and assert Rst_n after beat 2 → LOCK cleared. The next beat with Sel=1 goes to Output1.
